restoring_divider32: RTL and testbench

Sequential 32-bit unsigned integer divider built around one shared `fastAdder32` instance. The adder is wired as a subtractor: `cin=1`, operand B is the bitwise complement of the divisor. The controller runs one restoring-division iteration per clock, 32 iterations in total, and returns quotient and remainder with a start/done handshake. It sits beside the ALU as the multi-cycle divide resource.

---
 rtl/restoring_divider32_pkg.sv | 14 +
 rtl/fastAdder32.sv | 37 +++
 rtl/twoscomplement.sv | 9 +
 rtl/restoring_divider32.sv | 138 +++++++++++++
 tb/tb_restoring_divider32.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/restoring_divider32_pkg.sv
// Shared definitions for the 32-bit restoring divider: FSM encoding and constants.
package restoring_divider32_pkg;
  localparam int DIV_ITER = 32;
  localparam int CNT_W = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/fastAdder32.sv
// 32-bit adder: 4-bit groups with in-group ripple and lookahead carry between groups.
module fastAdder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  localparam int GRP_W = 4;
  localparam int NUM_GRP = 32 / GRP_W;

  logic [NUM_GRP:0] c;
  assign c[0] = cin;
  assign cout = c[NUM_GRP];

  for (genvar i = 0; i < NUM_GRP; i++) begin : g_grp
    logic [GRP_W-1:0] g, p, cc;
    logic gg, pg;
    assign g  = a[i*GRP_W +: GRP_W] & b[i*GRP_W +: GRP_W];
    assign p  = a[i*GRP_W +: GRP_W] ^ b[i*GRP_W +: GRP_W];
    assign pg = &p;

    always_comb begin
      gg = 1'b0;
      cc = '0;
      cc[0] = c[i];
      for (int j = 0; j < GRP_W; j++) begin
        gg = g[j] | (p[j] & gg);
        if (j > 0) cc[j] = g[j-1] | (p[j-1] & cc[j-1]);
      end
    end

    // group carry skips the in-group ripple chain
    assign c[i+1] = gg | (pg & c[i]);
    assign sum[i*GRP_W +: GRP_W] = p ^ cc;
  end
endmodule

// File: rtl/twoscomplement.sv
// Two's-complement negation, used by the signed build (RESTDIV_SIGNED_EN) only.
`ifdef RESTDIV_SIGNED_EN
module twoscomplement (
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = ~a + 32'd1;
endmodule
`endif

// File: rtl/restoring_divider32.sv
// Sequential 32-bit restoring divider, one iteration per clock on a shared subtractor.
// Optional signed mode via RESTDIV_SIGNED_EN (adds is_signed port and FIXUP state).
module restoring_divider32
  import restoring_divider32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
`ifdef RESTDIV_SIGNED_EN
  input  logic        is_signed,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [31:0] d_r, q_r, r_r;
  logic [31:0] rs, trial, q_nx, r_nx, dvd_in, dvs_in;
  logic rmsb, cout, take, fix_req, div0;

  assign rmsb = r_r[31];
  assign rs   = {r_r[30:0], q_r[31]};

  fastAdder32 u_add (
    .a   (rs),
    .b   (~d_r),
    .cin (1'b1),
    .sum (trial),
    .cout(cout)
  );

  // rmsb set means the 33-bit partial remainder already exceeds D
  assign take = rmsb | cout;
  assign q_nx = {q_r[30:0], take};
  assign r_nx = take ? trial : rs;
  assign div0 = (divisor == 32'd0);

`ifdef RESTDIV_SIGNED_EN
  logic sgn_r, neg_q_r, neg_r_r;
  logic [31:0] dvd_neg, dvs_neg, q_neg, r_neg;

  twoscomplement u_neg_dvd (.a(dividend), .y(dvd_neg));
  twoscomplement u_neg_dvs (.a(divisor),  .y(dvs_neg));
  twoscomplement u_neg_q   (.a(q_r),      .y(q_neg));
  twoscomplement u_neg_r   (.a(r_r),      .y(r_neg));

  assign dvd_in  = (is_signed && dividend[31]) ? dvd_neg : dividend;
  assign dvs_in  = (is_signed && divisor[31])  ? dvs_neg : divisor;
  assign fix_req = sgn_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (state == S_IDLE && start) begin
      sgn_r   <= is_signed;
      neg_q_r <= is_signed & (dividend[31] ^ divisor[31]);
      neg_r_r <= is_signed & dividend[31];
    end
  end
`else
  assign dvd_in  = dividend;
  assign dvs_in  = divisor;
  assign fix_req = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = div0 ? S_DONE : S_RUN;
      S_RUN:   if (cnt == LAST_ITER) state_n = fix_req ? S_FIXUP : S_DONE;
      S_FIXUP: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      d_r         <= '0;
      q_r         <= '0;
      r_r         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // status flags registered from next state so outputs are flop-driven
      busy <= (state_n != S_IDLE);
      done <= (state_n == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          if (div0) begin
            quotient    <= DIV0_QUOTIENT;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            d_r <= dvs_in;
            q_r <= dvd_in;
            r_r <= '0;
            cnt <= '0;
          end
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
          q_r <= q_nx;
          r_r <= r_nx;
          if (cnt == LAST_ITER && !fix_req) begin
            quotient    <= q_nx;
            remainder   <= r_nx;
            div_by_zero <= 1'b0;
          end
        end
`ifdef RESTDIV_SIGNED_EN
        S_FIXUP: begin
          quotient    <= neg_q_r ? q_neg : q_r;
          remainder   <= neg_r_r ? r_neg : r_r;
          div_by_zero <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_restoring_divider32.sv
// Directed bench for restoring_divider32 with a queue scoreboard of expected results.
module tb_restoring_divider32;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
`ifdef RESTDIV_SIGNED_EN
  logic        is_signed;
`endif

  always #5 clk = ~clk;

  restoring_divider32 dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
`ifdef RESTDIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drives start for one edge; returns at the negedge right after the accepting edge
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int lat);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    dividend = a;
    divisor  = b;
`ifdef RESTDIV_SIGNED_EN
    is_signed = sg;
`else
    if (sg) $display("[TB] signed request ignored in unsigned build");
`endif
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(input string tag, input logic chk_busy, input int n0);
    int n;
    exp_t e;
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      if (chk_busy) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, n, e.lat);
    chk({tag, "_q"}, quotient, e.q);
    chk({tag, "_r"}, remainder, e.r);
    chk({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, e.dz});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold"}, quotient, e.q);
  endtask

  initial begin
    int base;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
`ifdef RESTDIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    launch(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32);
    wait_done("d100_7", 1'b1, 0);
    launch(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 32);
    wait_done("dmax_1", 1'b0, 0);
    launch(32'hFFFFFFFF, 32'h80000001, 1'b0, 32'd1, 32'h7FFFFFFE, 1'b0, 32);
    wait_done("rmsb", 1'b0, 0);
    launch(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, 0);
    wait_done("div0", 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom >> (i * 8);
      b = b | 32'd1;
      launch(a, b, 1'b0, a / b, a % b, 1'b0, 32);
      wait_done("rand", 1'b0, 0);
    end

    // start pulsed mid-run must be ignored
    base = done_seen;
    launch(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 32);
    repeat (3) @(negedge clk);
    dividend = 32'd50; divisor = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_start", 1'b1, 4);
    repeat (40) @(negedge clk);
    chk("ign_done_cnt", done_seen - base, 32'd1);

    // reset during iteration 10 aborts without done
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    base = done_seen;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_seen - base, 32'd0);
    launch(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 32);
    wait_done("post_rst", 1'b0, 0);

`ifdef RESTDIV_SIGNED_EN
    launch(-32'sd7, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    wait_done("s_m7_2", 1'b1, 0);
    launch(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 33);
    wait_done("s_wrap", 1'b0, 0);
    launch(32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 0);
    wait_done("s_div0", 1'b0, 0);
    launch(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0, 32);
    wait_done("u_nofix", 1'b0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
